// File: rtl/udp_rx.sv
// udp_rx: receive-side UDP layer. Strips and decodes the 8-byte UDP header
// from the IP payload stream, forwards the UDP payload with a correctly
// placed last, and reports discarded or truncated frames through a drop code.
module udp_rx #(
    parameter logic [7:0]  UDP_PROTOCOL   = 8'h11,
    parameter bit          PORT_FILTER_EN = 1'b0,
    parameter logic [15:0] LISTEN_PORT    = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ip_rx_start,
    input  logic        ip_rx_hdr_is_valid,
    input  logic [7:0]  ip_rx_hdr_protocol,
    input  logic [31:0] ip_rx_hdr_src_ip_addr,
    input  logic [7:0]  ip_rx_data_in,
    input  logic        ip_rx_data_in_valid,
    input  logic        ip_rx_data_in_last,
    output logic        udp_rx_start,
    output logic        udp_rxo_hdr_is_valid,
    output logic [31:0] udp_rxo_hdr_src_ip_addr,
    output logic [15:0] udp_rxo_hdr_src_port,
    output logic [15:0] udp_rxo_hdr_dst_port,
    output logic [15:0] udp_rxo_hdr_data_length,
    output logic [7:0]  udp_rxo_data_out,
    output logic        udp_rxo_data_out_valid,
    output logic        udp_rxo_data_out_last,
    output logic        udp_rx_drop,
    output logic [2:0]  udp_rx_drop_code
);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAYLOAD,
        DRAIN
    } state_t;

    localparam logic [2:0] DROP_NOT_UDP    = 3'd1;
    localparam logic [2:0] DROP_BAD_LEN    = 3'd2;
    localparam logic [2:0] DROP_TRUNC_HDR  = 3'd3;
    localparam logic [2:0] DROP_FILTER     = 3'd4;
    localparam logic [2:0] DROP_ABORT      = 3'd5;
    localparam logic [2:0] DROP_SHORT_DATA = 3'd6;

    state_t      state_q;
    logic [2:0]  hdrCnt_q;
    logic [47:0] hdr_q;
    logic [15:0] payCnt_q;
    logic [31:0] srcIp_q;

    logic        start_q;
    logic        hdrValid_q;
    logic [31:0] outSrcIp_q;
    logic [15:0] outSrcPort_q;
    logic [15:0] outDstPort_q;
    logic [15:0] dataLen_q;
    logic [7:0]  dataOut_q;
    logic        dataValid_q;
    logic        dataLast_q;
    logic        drop_q;
    logic [2:0]  dropCode_q;

    logic        startOk;
    state_t      beatState;
    logic [2:0]  beatHdrCnt;
    logic [15:0] udpLen;
    logic [15:0] hdrDst;
    logic [15:0] hdrSrc;
    logic [15:0] lenMinus8;
    logic [15:0] payNext;
    logic        filterMiss;

    assign startOk    = ip_rx_hdr_is_valid && (ip_rx_hdr_protocol == UDP_PROTOCOL);
    assign hdrSrc     = hdr_q[47:32];
    assign hdrDst     = hdr_q[31:16];
    assign udpLen     = hdr_q[15:0];
    assign lenMinus8  = udpLen - 16'd8;
    assign payNext    = payCnt_q + 16'd1;
    assign filterMiss = PORT_FILTER_EN && (hdrDst != LISTEN_PORT);

    // A beat arriving with ip_rx_start belongs to the new frame, so the state
    // and header byte index seen by that beat are those of a fresh start.
    always_comb begin
        beatState  = state_q;
        beatHdrCnt = hdrCnt_q;
        if (ip_rx_start) begin
            beatState  = startOk ? HDR : DRAIN;
            beatHdrCnt = 3'd0;
        end
    end

    // Frame FSM: header decode, payload forwarding and drop reporting, with
    // all outputs registered; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            hdrCnt_q     <= '0;
            hdr_q        <= '0;
            payCnt_q     <= '0;
            srcIp_q      <= '0;
            start_q      <= 1'b0;
            hdrValid_q   <= 1'b0;
            outSrcIp_q   <= '0;
            outSrcPort_q <= '0;
            outDstPort_q <= '0;
            dataLen_q    <= '0;
            dataOut_q    <= '0;
            dataValid_q  <= 1'b0;
            dataLast_q   <= 1'b0;
            drop_q       <= 1'b0;
            dropCode_q   <= '0;
        end else begin
            start_q     <= 1'b0;
            drop_q      <= 1'b0;
            dataValid_q <= 1'b0;
            dataLast_q  <= 1'b0;

            if (ip_rx_start) begin
                srcIp_q    <= ip_rx_hdr_src_ip_addr;
                hdrCnt_q   <= '0;
                payCnt_q   <= '0;
                hdrValid_q <= 1'b0;
                state_q    <= beatState;
                if (state_q == HDR || state_q == PAYLOAD) begin
                    drop_q     <= 1'b1;
                    dropCode_q <= DROP_ABORT;
                end else if (!startOk) begin
                    drop_q     <= 1'b1;
                    dropCode_q <= DROP_NOT_UDP;
                end
            end

            if (ip_rx_data_in_valid) begin
                case (beatState)
                    HDR: begin
                        if (beatHdrCnt < 3'd6) begin
                            hdr_q <= {hdr_q[39:0], ip_rx_data_in};
                        end
                        hdrCnt_q <= beatHdrCnt + 3'd1;
                        if (beatHdrCnt != 3'd7) begin
                            if (ip_rx_data_in_last) begin
                                drop_q     <= 1'b1;
                                dropCode_q <= DROP_TRUNC_HDR;
                                state_q    <= IDLE;
                            end
                        end else if (udpLen < 16'd8) begin
                            drop_q     <= 1'b1;
                            dropCode_q <= DROP_BAD_LEN;
                            state_q    <= ip_rx_data_in_last ? IDLE : DRAIN;
                        end else if (filterMiss) begin
                            drop_q     <= 1'b1;
                            dropCode_q <= DROP_FILTER;
                            state_q    <= ip_rx_data_in_last ? IDLE : DRAIN;
                        end else begin
                            start_q      <= 1'b1;
                            hdrValid_q   <= 1'b1;
                            outSrcIp_q   <= srcIp_q;
                            outSrcPort_q <= hdrSrc;
                            outDstPort_q <= hdrDst;
                            dataLen_q    <= lenMinus8;
                            payCnt_q     <= '0;
                            if (lenMinus8 == 16'd0) begin
                                state_q <= ip_rx_data_in_last ? IDLE : DRAIN;
                            end else begin
                                state_q <= PAYLOAD;
                            end
                        end
                    end
                    PAYLOAD: begin
                        dataOut_q   <= ip_rx_data_in;
                        dataValid_q <= 1'b1;
                        payCnt_q    <= payNext;
                        if (payNext == dataLen_q || ip_rx_data_in_last) begin
                            dataLast_q <= 1'b1;
                            state_q    <= ip_rx_data_in_last ? IDLE : DRAIN;
                            if (ip_rx_data_in_last && payNext != dataLen_q) begin
                                drop_q     <= 1'b1;
                                dropCode_q <= DROP_SHORT_DATA;
                            end
                        end
                    end
                    DRAIN: begin
                        if (ip_rx_data_in_last) begin
                            state_q <= IDLE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign udp_rx_start            = start_q;
    assign udp_rxo_hdr_is_valid    = hdrValid_q;
    assign udp_rxo_hdr_src_ip_addr = outSrcIp_q;
    assign udp_rxo_hdr_src_port    = outSrcPort_q;
    assign udp_rxo_hdr_dst_port    = outDstPort_q;
    assign udp_rxo_hdr_data_length = dataLen_q;
    assign udp_rxo_data_out        = dataOut_q;
    assign udp_rxo_data_out_valid  = dataValid_q;
    assign udp_rxo_data_out_last   = dataLast_q;
    assign udp_rx_drop             = drop_q;
    assign udp_rx_drop_code        = dropCode_q;

endmodule

// File: doc/udp_rx.md
# udp_rx

Receive-side UDP layer: the counterpart of the UDP transmit block, sitting between the IP receive layer and user logic. Takes the per-frame IP header plus the byte-wide IP payload stream, strips and decodes the 8-byte UDP header, and forwards the UDP payload with a correctly placed `last`. Frames are discarded, with an error code reported, when they are not UDP, are malformed, or fail the optional destination-port filter.

## Interface
- `UDP_PROTOCOL`, 8'h11: IP protocol number accepted as UDP.
- `PORT_FILTER_EN`, 0: when 1, drop datagrams whose dst_port differs from `LISTEN_PORT`.
- `LISTEN_PORT`, 16'h0000: port compared when filtering.

- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `ip_rx_start` in 1: one-cycle pulse; the IP header fields are valid and a new frame begins.
- `ip_rx_hdr_is_valid` in 1: IP header passed IP-layer checks.
- `ip_rx_hdr_protocol` in 8: IP protocol field.
- `ip_rx_hdr_src_ip_addr` in 32: sender IP.
- `ip_rx_data_in` in 8: IP payload byte.
- `ip_rx_data_in_valid` in 1: byte qualifier. There is no backpressure.
- `ip_rx_data_in_last` in 1: final IP payload byte; qualified by valid.
- `udp_rx_start` out 1: one-cycle pulse; UDP header outputs valid.
- `udp_rxo_hdr_is_valid` out 1: header outputs hold a good datagram.
- `udp_rxo_hdr_src_ip_addr` out 32, `udp_rxo_hdr_src_port` out 16, `udp_rxo_hdr_dst_port` out 16: decoded header fields.
- `udp_rxo_hdr_data_length` out 16: UDP length minus 8.
- `udp_rxo_data_out` out 8, `udp_rxo_data_out_valid` out 1, `udp_rxo_data_out_last` out 1: payload stream.
- `udp_rx_drop` out 1: one-cycle pulse; `udp_rx_drop_code` out 3 is valid with it.

## Operation
- States: IDLE, HDR, PAYLOAD, DRAIN.
- IDLE:
  - Data beats without a prior `ip_rx_start` are ignored.
  - On `ip_rx_start`: latch src_ip, clear byte counter, clear `udp_rxo_hdr_is_valid`.
  - If `ip_rx_hdr_is_valid`=0 or the protocol differs from `UDP_PROTOCOL`: drop code 1, go DRAIN.
  - Otherwise go HDR.
- HDR: bytes 0..7 are src_port, dst_port, length, checksum, each MSB first. The checksum is ignored. After byte 7, evaluate in this priority order:
  - length<8: drop code 2, go DRAIN.
  - Filter mismatch: drop code 4, go DRAIN.
  - Otherwise: data_length = length−8, pulse `udp_rx_start`, set `udp_rxo_hdr_is_valid`.
  - Then, if data_length=0: go IDLE when byte 7 carried last, else DRAIN.
  - Otherwise go PAYLOAD.
- HDR truncation: `ip_rx_data_in_last` on bytes 0..6 gives drop code 3, go IDLE.
- PAYLOAD:
  - Forward each byte and increment a 16-bit payload counter.
  - `last` is asserted on byte number data_length.
  - `last` is also asserted on an earlier byte carrying `ip_rx_data_in_last`; this is drop code 6, informational, and the frame is still delivered.
  - After `last`: go IDLE if that input byte carried IP last, else DRAIN. IP padding bytes are never forwarded.
- DRAIN: discard bytes until `ip_rx_data_in_last`, then go IDLE.
- `ip_rx_start` in any state other than IDLE aborts the current frame:
  - If in HDR or PAYLOAD, pulse drop code 5. `last` is never emitted for the aborted frame.
  - Restart with the new header, as from IDLE.
  - A data beat in the same cycle as `ip_rx_start` is header byte 0 of the new frame.
- `udp_rxo_hdr_*` fields hold until the next accepted `ip_rx_start` or reset.

## Timing
- All outputs are registered. Every output resets to 0 one cycle after `reset` is sampled high, and the state returns to IDLE.
- Reset mid-frame: the remaining bytes of that frame are ignored; there is no drop pulse and no `last`.
- `udp_rx_start` and header-valid assert the cycle after header byte 7 is accepted.
- Payload latency is 1 cycle: an input byte accepted at cycle t appears at cycle t+1 with valid/last.
- `udp_rx_start` always precedes the first payload output by at least 1 cycle.
- The `udp_rx_drop` pulse occurs the cycle after the detecting beat or start.
- Throughput is one byte per cycle; idle gaps in valid are tolerated in every state.

## Test plan
- Good frame: protocol 0x11, header 1234/0050/000C/0000, then 4 payload bytes AA..DD with IP last on DD.
  - Expected: start pulse; src_port 0x1234; dst_port 0x0050; data_length 4; bytes AA..DD out; last on DD only.
- IP padding: UDP length 0x000A followed by 6 bytes.
  - Expected: 2 bytes forwarded, last on the 2nd; the 4 padding bytes are dropped; the next frame parses normally.
- Protocol 0x06 with 10 bytes.
  - Expected: drop code 1; no start, valid, or last.
- Length field 0x0004.
  - Expected: drop code 2.
- IP last on header byte 5.
  - Expected: drop code 3; state returns to IDLE.
- Abort: `ip_rx_start` mid-payload.
  - Expected: drop code 5; the second frame is decoded correctly.
- Reset: reset asserted mid-payload.
  - Expected: all outputs are 0 the next cycle; the following frame decodes correctly.
- Port filter: with `PORT_FILTER_EN`=1 and `LISTEN_PORT`=0x0050, send dst 0x0051, then dst 0x0050.
  - Expected: drop code 4 for the first; the second is delivered.
